// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a one-word holding register.
// Frame = start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    output logic              TX,
    output logic              tx_rdy,
    output logic              busy,
    output logic              tx_done
);

    localparam int BW = $clog2(DATA_W + 4);
    localparam int CW = $clog2(BAUD_DIV);

    // bit-count values (start bit included) at which a phase ends
    localparam logic [BW-1:0] DATA_END  = BW'(1 + DATA_W);
    localparam logic [BW-1:0] FRAME_END = BW'(1 + DATA_W + PARITY_EN + STOP_BITS);
    localparam logic [CW-1:0] BAUD_TOP  = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      baud_q, baud_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               full_q, full_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;

    logic               accept;
    logic               shift;
    logic               load;
    logic               finish;

    assign accept = trmt && !full_q;
    assign shift  = (state_q != IDLE) && (baud_q == BAUD_TOP);

    assign TX      = tx_q;
    assign tx_rdy  = !full_q;
    assign busy    = (state_q != IDLE);
    assign tx_done = done_q;

    // state, counters, data path and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // next-state, counter, holding register and line-level logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        hold_d  = hold_q;
        full_d  = full_q;
        par_d   = par_q;
        done_d  = done_q;
        tx_d    = tx_q;
        load    = 1'b0;
        finish  = 1'b0;

        if (accept) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end

        if (state_q != IDLE) begin
            baud_d = shift ? '0 : baud_q + 1'b1;
        end

        if (shift) begin
            bit_d = bit_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (shift) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (shift) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q + 1'b1 == DATA_END) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (shift) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (shift && (bit_q + 1'b1 == FRAME_END)) begin
                    if (full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a queued word starts its frame on the next clock
        if (load) begin
            state_d = START;
            shreg_d = hold_q;
            par_d   = (PARITY_ODD != 0) ? ~^hold_q : ^hold_q;
            full_d  = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
        end

        // completion wins over a same-cycle accept; a pending word clears it later
        if (finish) begin
            done_d = 1'b1;
        end else if (accept || full_q) begin
            done_d = 1'b0;
        end

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg in four frame formats.
// Accepted words are queued; a monitor checks every TX clock against a bit model.
module tb_uart_tx_cfg;

    localparam int BAUD = 16;
    localparam int NI   = 4;
    localparam int DW_T [NI] = '{8, 8, 8, 5};
    localparam int PE_T [NI] = '{0, 1, 1, 0};
    localparam int PO_T [NI] = '{0, 0, 1, 0};
    localparam int SB_T [NI] = '{1, 1, 2, 2};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] trmt_v = '0;
    logic [8:0]    d_bus [NI];
    logic [NI-1:0] TXv;
    logic [NI-1:0] rdy;
    logic [NI-1:0] bsy;
    logic [NI-1:0] dn;

    int total = 0;
    int errs  = 0;
    int cyc   = 0;

    logic [8:0] mq [NI][$];
    int         st_log [NI][$];
    logic       act [NI];
    int         pos [NI];
    int         cnt [NI];
    logic       bitbad [NI];
    logic       badlvl [NI];
    logic [8:0] cur [NI];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_cfg #(
            .DATA_W    (DW_T[g]),
            .BAUD_DIV  (BAUD),
            .PARITY_EN (PE_T[g]),
            .PARITY_ODD(PO_T[g]),
            .STOP_BITS (SB_T[g])
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .trmt   (trmt_v[g]),
            .tx_data(d_bus[g][DW_T[g]-1:0]),
            .TX     (TXv[g]),
            .tx_rdy (rdy[g]),
            .busy   (bsy[g]),
            .tx_done(dn[g])
        );
    end

    function automatic logic [8:0] msk(input int k);
        return 9'((1 << DW_T[k]) - 1);
    endfunction

    function automatic int nbits(input int k);
        return 1 + DW_T[k] + PE_T[k] + SB_T[k];
    endfunction

    // expected line level of bit i of the frame carrying word w
    function automatic logic bit_at(input int k, input logic [8:0] w, input int i);
        if (i == 0) return 1'b0;
        if (i <= DW_T[k]) return w[i-1];
        if (PE_T[k] != 0 && i == DW_T[k] + 1)
            return (($countones(w) + PO_T[k]) % 2) == 1;
        return 1'b1;
    endfunction

    function automatic void chk1(input string nm, input logic a, input logic e);
        total++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0b expected %0b", nm, a, e);
        end
    endfunction

    function automatic void chkn(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    act[k] = 1'b0;
                    mq[k].delete();
                end else if (act[k]) begin
                    if (TXv[k] !== bit_at(k, cur[k], pos[k])) begin
                        bitbad[k] = 1'b1;
                        badlvl[k] = TXv[k];
                    end
                    cnt[k]++;
                    if (cnt[k] == BAUD) begin
                        total++;
                        if (bitbad[k]) begin
                            errs++;
                            $display("FAIL tx_bit inst=%0d word=%0h bit=%0d: got %0b expected %0b",
                                     k, cur[k], pos[k], badlvl[k], bit_at(k, cur[k], pos[k]));
                        end
                        bitbad[k] = 1'b0;
                        cnt[k] = 0;
                        pos[k]++;
                        if (pos[k] == nbits(k)) act[k] = 1'b0;
                    end
                end else if (TXv[k] == 1'b0) begin
                    st_log[k].push_back(cyc);
                    total++;
                    if (mq[k].size() == 0) begin
                        errs++;
                        $display("FAIL unexpected_frame inst=%0d: got start bit expected idle line", k);
                        cur[k] = '0;
                    end else begin
                        cur[k] = mq[k].pop_front();
                    end
                    act[k]    = 1'b1;
                    pos[k]    = 0;
                    cnt[k]    = 1;
                    bitbad[k] = 1'b0;
                end
            end
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input int k, input logic [8:0] w);
        int n = 0;
        while (!rdy[k] && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy[k]) begin
            total++;
            errs++;
            $display("FAIL send_timeout inst=%0d: got tx_rdy=0 expected 1", k);
            return;
        end
        trmt_v[k] = 1'b1;
        d_bus[k]  = w;
        mq[k].push_back(w & msk(k));
        @(posedge clk); #1;
        trmt_v[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while ((bsy[k] || act[k] || mq[k].size() != 0) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk1("idle_reached", bsy[k] || act[k], 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic single(input int k, input logic [8:0] w);
        int n;
        send(k, w);
        n = 1;
        while (!dn[k] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chkn("frame_len", n, 2 + nbits(k) * BAUD);
        chk1("busy_at_done", bsy[k], 1'b0);
        wait_idle(k);
    endtask

    task automatic rand_run(input int k);
        for (int j = 0; j < 15; j++) begin
            automatic int gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 250) : 0;
            if (gap != 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send(k, 9'($urandom));
            if ($urandom_range(0, 3) == 0 && !rdy[k]) begin
                trmt_v[k] = 1'b1;
                d_bus[k]  = 9'($urandom);
                @(posedge clk); #1;
                trmt_v[k] = 1'b0;
            end
        end
    endtask

    initial begin
        int n;
        logic seen;
        for (int k = 0; k < NI; k++) begin
            d_bus[k] = '0;
            act[k] = 1'b0;
            pos[k] = 0;
            cnt[k] = 0;
            bitbad[k] = 1'b0;
            badlvl[k] = 1'b0;
            cur[k] = '0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_tx", TXv[0], 1'b1);
        chk1("rst_rdy", rdy[0], 1'b1);
        chk1("rst_busy", bsy[0], 1'b0);
        chk1("rst_done", dn[0], 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 0xA5: exact edge timing, then a same-cycle trmt at STOP -> IDLE
        trmt_v[0] = 1'b1;
        d_bus[0]  = 9'h0A5;
        mq[0].push_back(9'h0A5);
        @(posedge clk); #1;
        trmt_v[0] = 1'b0;
        chk1("rdy_fall", rdy[0], 1'b0);
        chk1("tx_idle_e1", TXv[0], 1'b1);
        @(posedge clk); #1;
        chk1("start_e2", TXv[0], 1'b0);
        chk1("rdy_e2", rdy[0], 1'b1);
        chk1("busy_e2", bsy[0], 1'b1);
        repeat (159) @(posedge clk);
        #1;
        chk1("busy_e161", bsy[0], 1'b1);
        chk1("done_e161", dn[0], 1'b0);
        trmt_v[0] = 1'b1;
        d_bus[0]  = 9'h05A;
        mq[0].push_back(9'h05A);
        @(posedge clk); #1;
        trmt_v[0] = 1'b0;
        chk1("done_e162", dn[0], 1'b1);
        chk1("busy_e162", bsy[0], 1'b0);
        chk1("rdy_e162", rdy[0], 1'b0);
        @(posedge clk); #1;
        chk1("done_pulse_end", dn[0], 1'b0);
        chk1("busy_e163", bsy[0], 1'b1);
        chk1("start_e163", TXv[0], 1'b0);
        wait_idle(0);

        // parity and short-word formats
        single(1, 9'h007);
        single(2, 9'h007);
        single(3, 9'h1FF);
        single(0, 9'h0C3);

        // queueing: back-to-back frames, trmt while full is dropped
        st_log[0].delete();
        send(0, 9'h055);
        n = 0;
        while (!rdy[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        send(0, 9'h0AA);
        chk1("rdy_full", rdy[0], 1'b0);
        trmt_v[0] = 1'b1;
        d_bus[0]  = 9'h0FF;
        @(posedge clk); #1;
        trmt_v[0] = 1'b0;
        seen = 1'b0;
        n = 0;
        while (st_log[0].size() < 2 && n < 400) begin
            if (dn[0]) seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chkn("b2b_starts", st_log[0].size(), 2);
        if (st_log[0].size() >= 2)
            chkn("b2b_gap", st_log[0][1] - st_log[0][0], 160);
        chk1("done_between", seen, 1'b0);
        wait_idle(0);

        // reset in the middle of a 0x00 frame with a word queued behind it
        send(0, 9'h000);
        send(0, 9'h081);
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_tx", TXv[0], 1'b1);
        chk1("mid_rst_rdy", rdy[0], 1'b1);
        chk1("mid_rst_busy", bsy[0], 1'b0);
        chk1("mid_rst_done", dn[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        single(0, 9'h03C);

        // randomized traffic on all formats at once
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
            rand_run(3);
        join
        for (int k = 0; k < NI; k++) wait_idle(k);
        for (int k = 0; k < NI; k++) chkn("queue_empty", mq[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, errs);
        $finish;
    end

endmodule
